// File: rtl/framebuffer_pkg.sv
// Shared types and defaults for the framebuffer line fetcher.
// Holds the fetch FSM encoding, the PSRAM address width and a counter-width helper.
package framebuffer_pkg;

  localparam int unsigned ADDR_W             = 21;
  localparam int unsigned H_ACTIVE_DEF       = 1280;
  localparam int unsigned PIXELS_PER_REQ_DEF = 32;
  localparam int unsigned BEATS_PER_REQ_DEF  = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StData  = 2'd2,
    StDrain = 2'd3
  } fetch_state_e;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/framebuffer_line_fetcher_if.sv
// Control, PSRAM and line-FIFO signals of the line fetcher, bundled as one interface.
// The master modport is the fetcher; the slave modport is its surroundings.
interface framebuffer_line_fetcher_if #(
  parameter int unsigned DATA_W = 64
) ();

  logic                              i_frame_start;
  logic                              i_line_start;
  logic                              o_psram_read_req;
  logic                              i_psram_read_gnt;
  logic [framebuffer_pkg::ADDR_W-1:0] o_psram_addr;
  logic [DATA_W-1:0]                 i_psram_data;
  logic                              i_psram_data_valid;
  logic [DATA_W-1:0]                 o_wr_data;
  logic                              o_wr_en;
  logic                              o_busy;
  logic                              o_line_done;
  logic                              o_underrun;

  modport master (
    input  i_frame_start, i_line_start, i_psram_read_gnt, i_psram_data, i_psram_data_valid,
    output o_psram_read_req, o_psram_addr, o_wr_data, o_wr_en, o_busy, o_line_done, o_underrun
  );

  modport slave (
    output i_frame_start, i_line_start, i_psram_read_gnt, i_psram_data, i_psram_data_valid,
    input  o_psram_read_req, o_psram_addr, o_wr_data, o_wr_en, o_busy, o_line_done, o_underrun
  );

endinterface

// File: rtl/framebuffer_addr_gen.sv
// Address generator: tracks the current source line base, the line repeat count
// and the PSRAM burst address presented with each read request.
module framebuffer_addr_gen
  import framebuffer_pkg::*;
#(
  parameter int unsigned       PIXELS_PER_REQ = PIXELS_PER_REQ_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = 21'h00_0000,
  parameter logic [ADDR_W-1:0] LINE_STRIDE    = 21'd1280,
  parameter int unsigned       LINE_REPEAT    = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              frame_start_i,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic              line_done_i,
  output logic [ADDR_W-1:0] addr_o
);

  if (LINE_REPEAT < 1 || LINE_REPEAT > 4) begin : g_bad_repeat
    $error("LINE_REPEAT must be in the range 1..4");
  end

  localparam logic [1:0]        RepLast   = 2'(LINE_REPEAT - 1);
  localparam logic [ADDR_W-1:0] BurstStep = ADDR_W'(PIXELS_PER_REQ);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        rep_q, rep_d;

  always_comb begin
    base_d = base_q;
    rep_d  = rep_q;
    addr_d = addr_q;
    if (frame_start_i) begin
      base_d = BASE_ADDR;
      rep_d  = '0;
    end else if (line_done_i) begin
      // The same source line is refetched until it has been output LINE_REPEAT times.
      if (rep_q == RepLast) begin
        rep_d  = '0;
        base_d = base_q + LINE_STRIDE;
      end else begin
        rep_d = rep_q + 2'd1;
      end
    end
    if (load_i) begin
      addr_d = base_q;
    end else if (advance_i) begin
      addr_d = addr_q + BurstStep;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q <= BASE_ADDR;
      rep_q  <= '0;
      addr_q <= '0;
    end else begin
      base_q <= base_d;
      rep_q  <= rep_d;
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/framebuffer_line_fetcher.sv
// Fetches one video line from PSRAM as a series of single-outstanding burst reads
// and forwards the returned beats to the line FIFO one cycle later.
module framebuffer_line_fetcher
  import framebuffer_pkg::*;
#(
  parameter int unsigned       H_ACTIVE       = H_ACTIVE_DEF,
  parameter int unsigned       PIXELS_PER_REQ = PIXELS_PER_REQ_DEF,
  parameter int unsigned       BEATS_PER_REQ  = BEATS_PER_REQ_DEF,
  parameter int unsigned       DATA_W         = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = 21'h00_0000,
  parameter logic [ADDR_W-1:0] LINE_STRIDE    = 21'd1280,
  parameter int unsigned       LINE_REPEAT    = 1
) (
  input logic                        i_clk,
  input logic                        i_rst_n,
  framebuffer_line_fetcher_if.master fetch_io
);

  if (PIXELS_PER_REQ == 0 || H_ACTIVE < PIXELS_PER_REQ ||
      (H_ACTIVE % PIXELS_PER_REQ) != 0) begin : g_bad_ratio
    $error("H_ACTIVE must be a non-zero integer multiple of PIXELS_PER_REQ");
  end

  localparam int unsigned REQS_PER_LINE = H_ACTIVE / PIXELS_PER_REQ;
  localparam int unsigned BeatW         = cnt_width(BEATS_PER_REQ);
  localparam int unsigned ReqW          = cnt_width(REQS_PER_LINE);
  localparam logic [BeatW-1:0] BeatLast = BeatW'(BEATS_PER_REQ - 1);
  localparam logic [ReqW-1:0]  ReqLast  = ReqW'(REQS_PER_LINE - 1);

  fetch_state_e      state_q, state_d;
  logic              req_q, req_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic [ReqW-1:0]   reqc_q, reqc_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              line_done_q, line_done_d;
  logic              underrun_q, underrun_d;
  logic              load, advance;
  logic              beat_last;
  logic [BeatW-1:0]  beat_next;

  assign beat_last = (beat_q == BeatLast);
  assign beat_next = beat_last ? '0 : beat_q + BeatW'(1);

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    beat_d      = beat_q;
    reqc_d      = reqc_q;
    wr_en_d     = 1'b0;
    wr_data_d   = fetch_io.i_psram_data;
    line_done_d = 1'b0;
    underrun_d  = fetch_io.i_line_start && (state_q != StIdle);
    load        = 1'b0;
    advance     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fetch_io.i_line_start && !fetch_io.i_frame_start) begin
          state_d = StReq;
          req_d   = 1'b1;
          reqc_d  = '0;
          beat_d  = '0;
          load    = 1'b1;
        end
      end
      StReq: begin
        if (fetch_io.i_psram_read_gnt) begin
          // A granted burst must still be consumed even if the frame restarts.
          req_d   = 1'b0;
          beat_d  = '0;
          state_d = fetch_io.i_frame_start ? StDrain : StData;
        end else if (fetch_io.i_frame_start) begin
          req_d   = 1'b0;
          state_d = StIdle;
        end
      end
      StData: begin
        if (fetch_io.i_psram_data_valid) begin
          beat_d = beat_next;
        end
        if (fetch_io.i_frame_start) begin
          state_d = (fetch_io.i_psram_data_valid && beat_last) ? StIdle : StDrain;
        end else if (fetch_io.i_psram_data_valid) begin
          wr_en_d = 1'b1;
          if (beat_last) begin
            if (reqc_q != ReqLast) begin
              state_d = StReq;
              req_d   = 1'b1;
              reqc_d  = reqc_q + ReqW'(1);
              advance = 1'b1;
            end else begin
              state_d     = StIdle;
              line_done_d = 1'b1;
            end
          end
        end
      end
      StDrain: begin
        if (fetch_io.i_psram_data_valid) begin
          beat_d = beat_next;
          if (beat_last) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      req_q       <= 1'b0;
      beat_q      <= '0;
      reqc_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      line_done_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      beat_q      <= beat_d;
      reqc_q      <= reqc_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      line_done_q <= line_done_d;
      underrun_q  <= underrun_d;
    end
  end

  framebuffer_addr_gen #(
    .PIXELS_PER_REQ(PIXELS_PER_REQ),
    .BASE_ADDR     (BASE_ADDR),
    .LINE_STRIDE   (LINE_STRIDE),
    .LINE_REPEAT   (LINE_REPEAT)
  ) u_addr_gen (
    .clk_i        (i_clk),
    .rst_ni       (i_rst_n),
    .frame_start_i(fetch_io.i_frame_start),
    .load_i       (load),
    .advance_i    (advance),
    .line_done_i  (line_done_d),
    .addr_o       (fetch_io.o_psram_addr)
  );

  assign fetch_io.o_psram_read_req = req_q;
  assign fetch_io.o_wr_data        = wr_data_q;
  assign fetch_io.o_wr_en          = wr_en_q;
  assign fetch_io.o_busy           = (state_q != StIdle);
  assign fetch_io.o_line_done      = line_done_q;
  assign fetch_io.o_underrun       = underrun_q;

endmodule

// File: doc/framebuffer_line_fetcher.md
FRAMEBUFFER_LINE_FETCHER -- requirements
Module: framebuffer_line_fetcher

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 11'd1280, meaning active pixels per line.
REQ-002 SHALL have parameter PIXELS_PER_REQ, default 32, meaning pixels delivered per PSRAM burst request.
REQ-003 SHALL have parameter BEATS_PER_REQ, default 8, meaning i_psram_data_valid beats per granted request.
REQ-004 SHALL have parameter DATA_W, default 64, meaning PSRAM data width.
REQ-005 SHALL have parameter BASE_ADDR, default 21'h00_0000, meaning frame start address.
REQ-006 SHALL have parameter LINE_STRIDE, default 21'd1280, meaning address increment between source lines.
REQ-007 SHALL have parameter LINE_REPEAT, default 1 (range 1..4), meaning output lines per source line.
REQ-008 Ports: i_clk in 1 (sole clock); i_rst_n in 1 (asynchronous, active-low reset); i_frame_start in 1 (frame start pulse); i_line_start in 1 (line fetch pulse); o_psram_read_req out 1; i_psram_read_gnt in 1; o_psram_addr out 21; i_psram_data in DATA_W; i_psram_data_valid in 1; o_wr_data out DATA_W (to line FIFO); o_wr_en out 1; o_busy out 1; o_line_done out 1 (pulse); o_underrun out 1 (pulse).

Function
REQ-009 REQS_PER_LINE = H_ACTIVE/PIXELS_PER_REQ, evaluated at elaboration; non-integer ratio SHALL be an elaboration error.
REQ-010 FSM states IDLE, REQ, DATA, DRAIN; reset state IDLE.
REQ-011 IDLE + i_line_start -> REQ; request counter cleared; o_psram_addr = line base address.
REQ-012 In REQ, o_psram_read_req SHALL be held high until i_psram_read_gnt is sampled high, then deasserted next cycle and FSM -> DATA.
REQ-013 o_psram_addr SHALL be stable whenever o_psram_read_req is high.
REQ-014 At most one request outstanding; beat counter counts i_psram_data_valid in DATA, 0..BEATS_PER_REQ-1.
REQ-015 On last beat: if request counter < REQS_PER_LINE-1, address += PIXELS_PER_REQ, counter +1, -> REQ; else -> IDLE and o_line_done pulses one cycle.
REQ-016 o_wr_data/o_wr_en SHALL be i_psram_data/i_psram_data_valid registered, latency 1 cycle, o_wr_en only for beats accepted in DATA.
REQ-017 Line base advances by LINE_STRIDE only after LINE_REPEAT completed lines (repeat counter wraps); otherwise same source line refetched.
REQ-018 i_frame_start: line base = BASE_ADDR, repeat counter = 0, takes priority over i_line_start in the same cycle.
REQ-019 i_frame_start in REQ without gnt same cycle: request dropped (req low next cycle), -> IDLE; with gnt same cycle: -> DRAIN.
REQ-020 i_frame_start in DATA -> DRAIN; DRAIN discards remaining beats of the granted burst (o_wr_en low), then -> IDLE; no o_line_done.
REQ-021 i_line_start while not IDLE: o_underrun pulses one cycle, current line continues, pulse otherwise ignored.
REQ-022 i_psram_data_valid in IDLE or REQ SHALL be ignored.
REQ-023 o_busy high whenever FSM not IDLE.
REQ-024 Address arithmetic 21-bit, wraps modulo 2^21 without flag.

Reset
REQ-025 On i_rst_n low: all outputs 0, FSM IDLE, all counters 0, line base = BASE_ADDR, immediately and asynchronously, including mid-burst.
REQ-026 Beats arriving after reset release for a pre-reset grant SHALL be ignored per REQ-022.

Structure
REQ-027 Shared package framebuffer_pkg holds FSM state encoding, ADDR_W = 21, default H_ACTIVE/PIXELS_PER_REQ/BEATS_PER_REQ.
REQ-028 One sub-module, framebuffer_addr_gen (line base, repeat counter, burst address); FSM and beat counting in top.

Verification (H_ACTIVE=64, PIXELS_PER_REQ=32, BEATS_PER_REQ=8, LINE_STRIDE=64, LINE_REPEAT=2)
REQ-029 frame_start, line_start, gnt 3 cycles after req -> addrs 0x000, 0x020; 16 o_wr_en beats with data matching 1 cycle late; one o_line_done.
REQ-030 Four line_starts after frame_start -> line bases 0x000, 0x000, 0x040, 0x040.
REQ-031 line_start during DATA -> o_underrun one cycle, addr sequence unchanged, line completes.
REQ-032 frame_start after 3rd beat of burst 1 -> remaining 5 beats produce no o_wr_en, no o_line_done, next line base 0x000.
REQ-033 frame_start coincident with gnt -> DRAIN, 8 beats discarded, IDLE after last; frame_start in REQ without gnt -> req low next cycle.
REQ-034 i_rst_n low mid-DATA -> all outputs 0 same cycle; late beats after release -> no o_wr_en.
